// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access-size codes, FSM states
// and the load-lane extraction helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD_RD = 2'b01,
    RESP    = 2'b10
  } state_t;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH x 32, per-byte write enables and a
// registered read port. Contents are not reset.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (i_we[n]) r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_unit.sv
// Load/store front end for the data RAM: byte/half/word access with lane
// enables and load extension. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_t      r_state;
  logic        r_resp_valid;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;

  logic        w_accept;
  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [3:0]  w_ram_we;
  logic        w_ram_re;
  logic [31:0] w_ram_rdata;
  logic        w_unused_addr;

  assign req_ready     = (r_state == IDLE);
  assign w_accept      = req_valid && req_ready;
  assign w_size        = (req_size == 2'b11) ? SZ_WORD : req_size;
  assign w_unused_addr = ^req_addr[31:AW+2];

  // Offset is forced to natural alignment; with the trap enabled a misaligned
  // request never writes, so the forced offset is harmless there too.
  always_comb begin
    w_off   = req_addr[1:0];
    w_mis   = 1'b0;
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_mis   = req_addr[0];
`endif
        w_off   = {req_addr[1], 1'b0};
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_mis   = |req_addr[1:0];
`endif
        w_off   = 2'b00;
        w_be    = 4'b1111;
      end
    endcase
  end

  assign w_ram_we = (w_accept && req_we && !w_mis) ? w_be : 4'b0000;
  assign w_ram_re = w_accept && !req_we && !w_mis;

  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (req_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= 32'd0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_size   <= w_size;
            r_signed <= req_signed;
            r_off    <= w_off;
            if (w_mis) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= 32'd0;
            end else if (req_we) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b0;
            end else begin
              r_state      <= LOAD_RD;
              r_err        <= 1'b0;
            end
          end
        end
        LOAD_RD: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_rdata      <= load_extract(r_size, r_signed, r_off, w_ram_rdata);
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: reset, word/byte/half access, wrap,
// misalignment handling and reset during an outstanding request.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int vecs = 0;
  int miss = 0;

  int          lat;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Issue one request, scramble the inputs right after the accept edge, then
  // report how many cycles later resp_valid appeared (0 = never within budget).
  task automatic drv(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output int l, output logic [31:0] r, output logic e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
    req_addr = addr ^ 32'hFFFF_FFFC; req_wdata = ~wd;
    l = 0; r = 32'hX; e = 1'bX;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        l = k; r = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (req_ready !== 1'b1) begin miss++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    vecs++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    vecs++; if (resp_err !== 1'b0) begin miss++; $display("FAIL rst_err: got %b want 0", resp_err); end
    vecs++; if (resp_rdata !== 32'd0) begin miss++; $display("FAIL rst_rdata: got %h want 00000000", resp_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    drv(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    vecs++; if (lat !== 1) begin miss++; $display("FAIL sw_latency: got %0d want 1", lat); end
    vecs++; if (er !== 1'b0) begin miss++; $display("FAIL sw_err: got %b want 0", er); end
    drv(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (lat !== 2) begin miss++; $display("FAIL lw_latency: got %0d want 2", lat); end
    vecs++; if (rd !== 32'hDEADBEEF) begin miss++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    vecs++; if (er !== 1'b0) begin miss++; $display("FAIL lw_err: got %b want 0", er); end
  endtask

  task automatic test_byte();
    drv(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF5A, lat, rd, er);
    vecs++; if (rd !== 32'hDEADBEEF) begin miss++; $display("FAIL sb_holds_rdata: got %h want deadbeef", rd); end
    drv(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hDE5ABEEF) begin miss++; $display("FAIL sb_merge: got %h want de5abeef", rd); end
    drv(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hFFFFFFDE) begin miss++; $display("FAIL lb_signed: got %h want ffffffde", rd); end
    drv(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h000000DE) begin miss++; $display("FAIL lbu: got %h want 000000de", rd); end
    drv(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h0000005A) begin miss++; $display("FAIL lb_positive: got %h want 0000005a", rd); end
    drv(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h000000EF) begin miss++; $display("FAIL lbu_lane0: got %h want 000000ef", rd); end
  endtask

  task automatic test_half();
    drv(1'b1, 2'b10, 1'b0, 32'h10, 32'h12348001, lat, rd, er);
    drv(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hFFFF8001) begin miss++; $display("FAIL lh_signed: got %h want ffff8001", rd); end
    drv(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h00008001) begin miss++; $display("FAIL lhu: got %h want 00008001", rd); end
    drv(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h00001234) begin miss++; $display("FAIL lh_upper: got %h want 00001234", rd); end
    drv(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFFABCD, lat, rd, er);
    drv(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hABCD8001) begin miss++; $display("FAIL sh_merge: got %h want abcd8001", rd); end
  endtask

  task automatic test_wrap();
    drv(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, lat, rd, er);
    drv(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hCAFEF00D) begin miss++; $display("FAIL wrap: got %h want cafef00d", rd); end
    drv(1'b0, 2'b11, 1'b1, 32'h8000_0000, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hCAFEF00D) begin miss++; $display("FAIL size11_word: got %h want cafef00d", rd); end
    vecs++; if (lat !== 2) begin miss++; $display("FAIL size11_latency: got %0d want 2", lat); end
  endtask

  task automatic test_misalign();
    drv(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, lat, rd, er);
    drv(1'b1, 2'b10, 1'b0, 32'h31, 32'h0BADF00D, lat, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs++; if (lat !== 1) begin miss++; $display("FAIL mis_latency: got %0d want 1", lat); end
    vecs++; if (er !== 1'b1) begin miss++; $display("FAIL mis_err: got %b want 1", er); end
    vecs++; if (rd !== 32'd0) begin miss++; $display("FAIL mis_rdata: got %h want 00000000", rd); end
    drv(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h11223344) begin miss++; $display("FAIL mis_nowrite: got %h want 11223344", rd); end
    drv(1'b0, 2'b01, 1'b1, 32'h33, 32'h0, lat, rd, er);
    vecs++; if (er !== 1'b1) begin miss++; $display("FAIL mis_lh_err: got %b want 1", er); end
    vecs++; if (lat !== 1) begin miss++; $display("FAIL mis_lh_latency: got %0d want 1", lat); end
`else
    vecs++; if (er !== 1'b0) begin miss++; $display("FAIL mis_err: got %b want 0", er); end
    drv(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h0BADF00D) begin miss++; $display("FAIL mis_aligned_write: got %h want 0badf00d", rd); end
    drv(1'b0, 2'b01, 1'b1, 32'h33, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h00000BAD) begin miss++; $display("FAIL mis_lh_aligned: got %h want 00000bad", rd); end
    vecs++; if (er !== 1'b0) begin miss++; $display("FAIL mis_lh_err: got %b want 0", er); end
`endif
  endtask

  task automatic test_reset_midload();
    int seen;
    drv(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'hABCD8001) begin miss++; $display("FAIL pre_rst_load: got %h want abcd8001", rd); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    vecs++; if (req_ready !== 1'b0) begin miss++; $display("FAIL loadrd_ready: got %b want 0", req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (req_ready !== 1'b1) begin miss++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    vecs++; if (resp_rdata !== 32'd0) begin miss++; $display("FAIL abort_rdata: got %h want 00000000", resp_rdata); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    vecs++; if (seen !== 0) begin miss++; $display("FAIL abort_no_resp: got %0d pulses want 0", seen); end
  endtask

  task automatic test_reset_store();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40;
    req_wdata = 32'h600DCAFE;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = 32'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drv(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er);
    vecs++; if (rd !== 32'h600DCAFE) begin miss++; $display("FAIL store_survives_rst: got %h want 600dcafe", rd); end
    vecs++; if (lat !== 2) begin miss++; $display("FAIL post_rst_latency: got %0d want 2", lat); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap();
    test_misalign();
    test_reset_midload();
    test_reset_store();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the data memory (power of two, 16..4096).
REQ-002 Parameter AW, default $clog2(DEPTH), word-index width derived from DEPTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-009 req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, feeds memory-side input of the writeback 2:1 mux.
REQ-014 resp_err  output  1  misaligned-access flag, valid with resp_valid.

Function
REQ-015 Handshake: transfer when req_valid && req_ready at a rising edge; req_ready=1 only in state IDLE.
REQ-016 FSM states IDLE, LOAD_RD, RESP; IDLE->LOAD_RD on accepted load; IDLE->RESP on accepted store or error; LOAD_RD->RESP unconditionally; RESP->IDLE unconditionally.
REQ-017 resp_valid=1 only in RESP; load latency 2 cycles after accept edge, store/error latency 1 cycle.
REQ-018 Word index = req_addr[AW+1:2]; upper address bits ignored (wrap-around, no error).
REQ-019 Byte lanes little-endian: byte n of the word = bits [8n+7:8n], n = addr[1:0].
REQ-020 Store byte/half writes only addressed lanes (per-lane write enable); other lanes unchanged; write occurs on the accept edge.
REQ-021 Load extracts addressed byte/half, extends per req_signed to 32 bits; word loads ignore req_signed.
REQ-022 resp_rdata held at last load value outside RESP; stores do not modify resp_rdata.
REQ-023 Request fields registered at accept; input changes after accept have no effect.
REQ-024 Memory contents undefined at power-up; not cleared by rst.

Reset
REQ-025 rst=1 at a rising edge forces IDLE, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 next cycle.
REQ-026 rst during LOAD_RD or RESP aborts the response (no resp_valid); a store already written on its accept edge remains written.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN: when defined, half with addr[0]=1 or word with addr[1:0]!=0 performs no write, returns resp_rdata=0, resp_err=1, 1-cycle latency.
REQ-028 Without DMEM_MISALIGN_TRAP_EN: low address bits below access size are forced to 0 (natural alignment) and resp_err is constant 0.

Structure
REQ-029 Package dmem_pkg holds size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-030 Sub-module dmem_ram: single-port synchronous RAM, DEPTH x 32, 4-bit byte write enable, one-cycle registered read.

Verification
REQ-031 Store word 0xDEADBEEF @0x10, load word @0x10 -> resp_rdata 0xDEADBEEF, resp_valid 2 cycles after accept, resp_err 0.
REQ-032 After REQ-031, store byte 0x5A @0x12, load word @0x10 -> 0xDE5ABEEF; load signed byte @0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-033 Load signed half @0x10 with word 0x1234_8001 -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-034 DEPTH=256: store word 0xCAFEF00D @0x400 -> load @0x000 returns 0xCAFEF00D (wrap).
REQ-035 With DMEM_MISALIGN_TRAP_EN, store word @0x11 -> resp_err 1, rdata 0, memory @0x10 unchanged; without it, same store writes @0x10, resp_err 0.
REQ-036 Assert rst in LOAD_RD -> no resp_valid, req_ready 1 cycle after reset edge, resp_rdata 0.
